traffic_phase_scheduler: RTL
============================

Name: traffic_phase_scheduler

Overview:
- Round-robin phase scheduler for an N-approach signalised intersection; generalises the two-road main/side controller to N approaches.
- Grants green to one requesting approach at a time and sequences green -> yellow -> all-red clearance.
- Enforces minimum and maximum green times with a single internal dwell timer.
- Outputs drive the lamp drivers directly, one red/yellow/green triple per approach.

Parameters:
- N_APP, 4, number of approaches (2..8).
- T_MIN_G, 4, minimum green dwell in Clk cycles (>=1).
- T_MAX_G, 14, maximum green dwell in cycles when another approach is waiting (>T_MIN_G).
- T_YEL, 4, yellow dwell in cycles (>=1).
- T_AR, 1, all-red clearance dwell in cycles (>=1).
- TW, 5, timer width in bits; must hold T_MAX_G.

Ports:
- Clk  input  1  clock; all state changes on rising edge.
- reset  input  1  synchronous, active-high.
- req  input  N_APP  level vehicle-presence sensors; bit i = approach i; sampled each Clk edge.
- green  output  N_APP  green lamp per approach.
- yellow  output  N_APP  yellow lamp per approach.
- red  output  N_APP  red lamp per approach.
- cur  output  3  index of the approach currently in green or yellow; last served approach while in ALL_RED.
- all_red  output  1  high while in the ALL_RED state.

Behaviour:
- Reset: synchronous, active-high, sampled on Clk.
  - Reset values: state=ALL_RED, timer=0, ptr=0, cur=0, green=0, yellow=0, red=all ones, all_red=1.
  - Reset asserted mid-green or mid-yellow forces these values on the next edge; no yellow is shown on reset.
- Outputs are registered.
  - For every approach exactly one of red/yellow/green is high.
  - At most one approach is non-red at any time.
- Timer:
  - Cleared to 0 on the edge that enters a state; otherwise +1 per cycle.
  - Saturates at 2^TW-1; never wraps.
  - "Dwell T complete" means timer == T-1, so a state lasts T cycles minimum.
- ALL_RED:
  - While dwell T_AR is incomplete, stay.
  - Once complete, if any req bit is high, choose the first set bit scanning circularly from index ptr. Go to GREEN with cur=that index on the next edge.
  - Once complete, if req == 0, stay in ALL_RED and re-evaluate every cycle; the timer saturates.
- GREEN(cur): let others = req with bit cur masked off.
  - Before T_MIN_G is complete: stay, regardless of req.
  - After T_MIN_G and before T_MAX_G: go to YELLOW if others != 0 and req[cur] == 0 (gap-out).
  - At T_MAX_G complete or later: go to YELLOW if others != 0 (max-out), even with req[cur] high.
  - If others == 0: hold green indefinitely; the timer saturates. If another request arrives later with the timer already past T_MAX_G-1, go to YELLOW on the next edge.
- YELLOW(cur):
  - Lasts exactly T_YEL cycles, then ALL_RED.
  - On the YELLOW->ALL_RED edge, ptr <= (cur+1) mod N_APP.
- Fairness: because of round-robin from ptr, a continuously requesting approach waits at most N_APP-1 service slots.
- Simultaneous events: req changes on the same edge as a transition use the sampled value only. Requests for the current approach during YELLOW are ignored; they are served only in a later rotation.
- Latencies: req edge -> green in ALL_RED (idle, dwell complete) = 1 cycle. Full changeover from gap-out = T_YEL + T_AR + 1 cycles to the next green.

Test Plan:
- Reset held 2 cycles then released, req=0 -> red=4'b1111, all_red=1, green=0 indefinitely; cur=0.
- From idle, req=4'b0100 -> green=4'b0100 one cycle later, cur=2. Keep req=0100 for 30 cycles -> green held, no yellow.
- Approach 0 green, req=4'b1001 held high -> green lasts exactly 14 cycles, then yellow[0] for 4, all-red 1, then green[3], cur=3.
- Approach 1 green, req[1] drops at cycle 2 with req[2]=1 -> green lasts 4 cycles (min-green), then yellow for 4 cycles, then green[2].
- req=4'b1111 constant -> service order 0,1,2,3,0; each green 14 cycles; one-hot lamp invariant checked every cycle.
- Reset asserted during yellow[2] -> next edge: red=1111, yellow=0, ptr=0. After release with req=0100, green[2] is served again.

Source files
------------

// File: rtl/traffic_phase_scheduler.sv
// Round-robin phase scheduler for an N-approach signalised intersection.
// One approach at a time gets green, then yellow, then an all-red clearance.
// A single dwell timer enforces minimum/maximum green, yellow and all-red times.
// All lamp outputs are registered and derived from the next state, so they
// change on the same edge as the state.
module traffic_phase_scheduler #(
  parameter int N_APP   = 4,
  parameter int T_MIN_G = 4,
  parameter int T_MAX_G = 14,
  parameter int T_YEL   = 4,
  parameter int T_AR    = 1,
  parameter int TW      = 5
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic [N_APP-1:0] req,
  output logic [N_APP-1:0] green,
  output logic [N_APP-1:0] yellow,
  output logic [N_APP-1:0] red,
  output logic [2:0]       cur,
  output logic             all_red
);

  typedef enum logic [1:0] {
    S_ALL_RED = 2'd0,
    S_GREEN   = 2'd1,
    S_YELLOW  = 2'd2
  } state_t;

  // Dwell-complete thresholds: a state lasting T cycles is done at timer == T-1.
  localparam logic [TW-1:0] AR_DONE  = TW'(T_AR - 1);
  localparam logic [TW-1:0] MIN_DONE = TW'(T_MIN_G - 1);
  localparam logic [TW-1:0] MAX_DONE = TW'(T_MAX_G - 1);
  localparam logic [TW-1:0] YEL_DONE = TW'(T_YEL - 1);
  localparam logic [TW-1:0] TIM_SAT  = {TW{1'b1}};

  state_t           state, state_nxt;
  logic [TW-1:0]    timer;
  logic [2:0]       ptr, ptr_nxt, cur_nxt;
  logic [3:0]       scan_idx;
  logic [2:0]       pick_idx;
  logic             pick_vld;
  logic [N_APP-1:0] cur_mask, others;
  logic             cur_req;
  logic [N_APP-1:0] lamp_sel, green_nxt, yellow_nxt;

  assign cur_mask = N_APP'(1) << cur;
  assign others   = req & ~cur_mask;
  assign cur_req  = |(req & cur_mask);

  // Circular priority pick starting at ptr; scanning downwards lets the
  // lowest offset from ptr overwrite any later candidate.
  always_comb begin
    pick_vld = 1'b0;
    pick_idx = '0;
    scan_idx = '0;
    for (int k = N_APP - 1; k >= 0; k--) begin
      scan_idx = {1'b0, ptr} + 4'(k);
      if (scan_idx >= 4'(N_APP)) scan_idx = scan_idx - 4'(N_APP);
      if (|(req & (N_APP'(1) << scan_idx))) begin
        pick_vld = 1'b1;
        pick_idx = scan_idx[2:0];
      end
    end
  end

  // Next-state, next served approach and next round-robin pointer.
  always_comb begin
    state_nxt = state;
    cur_nxt   = cur;
    ptr_nxt   = ptr;
    case (state)
      S_ALL_RED: begin
        if (timer >= AR_DONE && pick_vld) begin
          state_nxt = S_GREEN;
          cur_nxt   = pick_idx;
        end
      end
      S_GREEN: begin
        if (timer >= MAX_DONE) begin
          if (others != '0) state_nxt = S_YELLOW;        // max-out
        end else if (timer >= MIN_DONE && others != '0 && !cur_req) begin
          state_nxt = S_YELLOW;                           // gap-out
        end
      end
      S_YELLOW: begin
        if (timer >= YEL_DONE) begin
          state_nxt = S_ALL_RED;
          ptr_nxt   = (cur == 3'(N_APP - 1)) ? 3'd0 : cur + 3'd1;
        end
      end
      default: state_nxt = S_ALL_RED;
    endcase
  end

  // Lamp pattern implied by the next state.
  always_comb begin
    lamp_sel   = N_APP'(1) << cur_nxt;
    green_nxt  = (state_nxt == S_GREEN)  ? lamp_sel : '0;
    yellow_nxt = (state_nxt == S_YELLOW) ? lamp_sel : '0;
  end

  // State register.
  always_ff @(posedge Clk) begin
    if (reset) state <= S_ALL_RED;
    else       state <= state_nxt;
  end

  // Dwell timer, pointers and registered lamp outputs.
  always_ff @(posedge Clk) begin
    if (reset) begin
      timer   <= '0;
      ptr     <= '0;
      cur     <= '0;
      green   <= '0;
      yellow  <= '0;
      red     <= '1;
      all_red <= 1'b1;
    end else begin
      if (state_nxt != state)  timer <= '0;
      else if (timer != TIM_SAT) timer <= timer + TW'(1);
      ptr     <= ptr_nxt;
      cur     <= cur_nxt;
      green   <= green_nxt;
      yellow  <= yellow_nxt;
      red     <= ~(green_nxt | yellow_nxt);
      all_red <= (state_nxt == S_ALL_RED);
    end
  end

endmodule
